// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared states, default widths and beat-count helpers for the FIFO stream reader
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_OUT_WIDTH  = 8;
  localparam int DEFAULT_ERR_WIDTH  = 8;

  // Number of narrow beats per FIFO word.
  function automatic int beats_of(input int data_width, input int out_width);
    return data_width / out_width;
  endfunction

  // Beat counter width, never narrower than one bit.
  function automatic int cnt_w_of(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port and narrow output stream bundle
interface fifo_stream_reader_if
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH
);

  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic [OUT_WIDTH-1:0]  m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    input  fifo_empty, fifo_dout, fifo_rd_en, m_ready,
    output fifo_pop, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_empty, fifo_dout, fifo_rd_en, m_ready,
    input  fifo_pop, m_data, m_valid, m_last
  );

endinterface

// File: rtl/fifo_stream_shifter.sv
// rtl/fifo_stream_shifter.sv - word shift register, beat counter and last-beat detect
module fifo_stream_shifter
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [OUT_WIDTH-1:0]  beat,
  output logic                  last
);

  localparam int BEATS = beats_of(DATA_WIDTH, OUT_WIDTH);
  localparam int CNT_W = cnt_w_of(BEATS);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      beat_cnt_q;

  // Load a fresh word, or drop the accepted low chunk and count the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      beat_cnt_q <= '0;
    end else if (load) begin
      shift_q    <= load_data;
      beat_cnt_q <= '0;
    end else if (advance) begin
      shift_q    <= shift_q >> OUT_WIDTH;
      beat_cnt_q <= beat_cnt_q + CNT_W'(1);
    end
  end

  assign beat = shift_q[OUT_WIDTH-1:0];
  assign last = (beat_cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO pop engine serialising words into narrow beats; FIFO_STREAM_READER_PREFETCH_EN pops from the last beat
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH,
  parameter int ERR_WIDTH  = DEFAULT_ERR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_reader_if.master bus,
  output logic                 busy,
  output logic [ERR_WIDTH-1:0] err_cnt
);

  state_t               state_q, state_d;
  logic                 pop_q, pop_d;
  logic                 load, advance, err_inc;
  logic [OUT_WIDTH-1:0] beat;
  logic                 last;

  fifo_stream_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .advance   (advance),
    .load_data (bus.fifo_dout),
    .beat      (beat),
    .last      (last)
  );

  // Next state, pop request and shifter/error strobes from the current state.
  always_comb begin
    state_d = state_q;
    pop_d   = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    err_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty) begin
          pop_d   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.fifo_rd_en) begin
          load    = 1'b1;
          state_d = SEND;
        end else begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      SEND: begin
        if (bus.m_ready) begin
          advance = 1'b1;
          if (last) begin
`ifdef FIFO_STREAM_READER_PREFETCH_EN
            if (!bus.fifo_empty) begin
              pop_d   = 1'b1;
              state_d = WAIT;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered one-cycle pop request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pop_q   <= pop_d;
    end
  end

  // Count pops that came back without data, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_inc && (err_cnt != {ERR_WIDTH{1'b1}})) begin
      err_cnt <= err_cnt + ERR_WIDTH'(1);
    end
  end

  assign bus.fifo_pop = pop_q;
  assign bus.m_valid  = (state_q == SEND);
  assign bus.m_data   = (state_q == SEND) ? beat : '0;
  assign bus.m_last   = (state_q == SEND) && last;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - scoreboard bench for fifo_stream_reader
module tb_fifo_stream_reader;

  localparam int DW    = 32;
  localparam int OW    = 8;
  localparam int BEATS = DW / OW;
`ifdef FIFO_STREAM_READER_PREFETCH_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy1, busy2;
  logic [7:0] err1;
  logic [1:0] err2;

  fifo_stream_reader_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) sif ();
  fifo_stream_reader_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) sif2 ();

  assign sif2.fifo_empty = sif.fifo_empty;
  assign sif2.fifo_dout  = sif.fifo_dout;
  assign sif2.fifo_rd_en = sif.fifo_rd_en;
  assign sif2.m_ready    = sif.m_ready;

  fifo_stream_reader #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .ERR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(sif), .busy(busy1), .err_cnt(err1)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .ERR_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(sif2), .busy(busy2), .err_cnt(err2)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[$];
  logic [OW:0]   exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int valid_cnt = 0;
  int hs_cnt = 0;
  int cyc_aa = 0, cyc_dd = 0, cyc_11 = 0, cyc_88 = 0;
  bit prev_stall = 0;
  bit prev_pop = 0;
  logic [OW-1:0] prev_data;
  logic prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w, input bit expect_out);
    fq.push_back(w);
    sif.fifo_empty = 1'b0;
    if (expect_out)
      for (int i = 0; i < BEATS; i++)
        exp_q.push_back({(i == BEATS - 1), w[i*OW +: OW]});
  endtask

  // One clock: FIFO model, output monitor and scoreboard, sampled mid-cycle.
  task automatic tick(input logic rdy);
    logic [OW:0] e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (sif.fifo_pop) begin
      pop_cnt++;
      check("pop_single_cycle", {31'd0, prev_pop}, 32'd0);
      if (fq.size() > 0) sif.fifo_dout = fq.pop_front();
    end
    prev_pop = sif.fifo_pop;
    sif.fifo_empty = (fq.size() == 0);
    sif.m_ready = rdy;
    if (sif.m_valid) valid_cnt++;
    if (prev_stall) begin
      check("stall_hold", {22'd0, sif.m_valid, sif.m_last, sif.m_data},
            {22'd0, 1'b1, prev_last, prev_data});
    end
    if (sif.m_valid && sif.m_ready) begin
      hs_cnt++;
      if (sif.m_data == 8'hAA) cyc_aa = cyc;
      if (sif.m_data == 8'hDD) cyc_dd = cyc;
      if (sif.m_data == 8'h11) cyc_11 = cyc;
      if (sif.m_data == 8'h88) cyc_88 = cyc;
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_beat observed=%0h expected=none", sif.m_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", {23'd0, sif.m_last, sif.m_data}, {23'd0, e});
      end
    end
    prev_stall = sif.m_valid && !sif.m_ready;
    prev_data  = sif.m_data;
    prev_last  = sif.m_last;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0 || busy1) && n < 200) begin
      tick(1'b1);
      n++;
    end
    vectors++;
    assert (n < 200) else begin
      miscompares++;
      $error("FAIL %s_timeout observed=%0d expected=<200", tag, n);
    end
  endtask

  initial begin
    int p0, h0, v0, n;
    rst_n = 1'b0;
    sif.fifo_empty = 1'b1;
    sif.fifo_dout  = '0;
    sif.fifo_rd_en = 1'b1;
    sif.m_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {28'd0, sif.fifo_pop, sif.m_valid, sif.m_last, busy1}, 32'd0);
    check("rst_data_err", {16'd0, sif.m_data, err1}, 32'd0);
    rst_n = 1'b1;

    // Empty FIFO: nothing happens.
    repeat (20) tick(1'b1);
    check("idle_pop", pop_cnt, 0);
    check("idle_valid", valid_cnt, 0);
    check("idle_busy_err", {23'd0, busy1, err1}, 32'd0);

    // Single word, ready held high.
    p0 = pop_cnt; h0 = hs_cnt;
    push_word(32'hDDCCBBAA, 1'b1);
    drain("basic");
    check("basic_pops", pop_cnt - p0, 1);
    check("basic_beats", hs_cnt - h0, BEATS);
    check("basic_consecutive", cyc_dd - cyc_aa, BEATS - 1);
    check("basic_idle", {31'd0, busy1}, 32'd0);

    // Same word with a stalling consumer.
    h0 = hs_cnt;
    push_word(32'hDDCCBBAA, 1'b1);
    n = 0;
    while (!sif.m_valid && n < 20) begin tick(1'b0); n++; end
    check("stall_valid_seen", {31'd0, sif.m_valid}, 32'd1);
    tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b1);
    tick(1'b0); tick(1'b1); tick(1'b1);
    check("stall_beats", hs_cnt - h0, BEATS);
    check("stall_sb_empty", exp_q.size(), 0);
    drain("stall");

    // Back-to-back words.
    p0 = pop_cnt;
    push_word(32'h11223344, 1'b1);
    push_word(32'h55667788, 1'b1);
    drain("b2b");
    check("b2b_pops", pop_cnt - p0, 2);
    check("b2b_gap", cyc_88 - cyc_11, GAP);

    // Pops that return no data.
    sif.fifo_rd_en = 1'b0;
    v0 = valid_cnt;
    repeat (3) push_word(32'hDEADBEEF, 1'b0);
    drain("err3");
    check("err_cnt3", err1, 3);
    check("err_no_valid", valid_cnt - v0, 0);
    repeat (2) push_word(32'hCAFEF00D, 1'b0);
    drain("err5");
    check("err_cnt5", err1, 5);
    check("err_sat", err2, 3);
    sif.fifo_rd_en = 1'b1;

    // Reset in the middle of a word.
    h0 = hs_cnt;
    push_word(32'hDDCCBBAA, 1'b1);
    n = 0;
    while (hs_cnt - h0 < 2 && n < 40) begin tick(1'b1); n++; end
    check("rst_mid_two_beats", hs_cnt - h0, 2);
    tick(1'b0);
    check("pre_rst_valid", {31'd0, sif.m_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst", {28'd0, sif.m_valid, sif.m_last, sif.fifo_pop, busy1}, 32'd0);
    check("async_rst_err", err1, 0);
    exp_q.delete();
    prev_stall = 0;
    repeat (2) tick(1'b1);
    rst_n = 1'b1;
    p0 = pop_cnt; v0 = valid_cnt;
    repeat (10) tick(1'b1);
    check("post_rst_pop", pop_cnt - p0, 0);
    check("post_rst_valid", valid_cnt - v0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
